rat_add_sub_arbiter: RTL and testbench

Shares one rational add_sub datapath among NREQ requesters using round-robin arbitration. The block accepts one operation per requester via a valid/ready handshake and drives the add_sub operand and mode inputs stable for the whole operation. It captures the unit's (s_num, s_den) result when the unit's rdy asserts and returns it tagged with the requester index. It sits between the rational-expression sequencers and the single add_sub instance.

---
 rtl/rat_add_sub_arbiter.sv | 136 +++++++++++++
 tb/tb_rat_add_sub_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rat_add_sub_arbiter.sv
// Round-robin front end for a single shared rational add_sub unit: grants one
// requester at a time, holds the unit's operands stable and returns the tagged result.
module rat_add_sub_arbiter #(
  parameter int WIDTH    = 32,
  parameter int NREQ     = 4,
  parameter int IDW      = 2,
  parameter int MAX_WAIT = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ-1:0]       req_sub,
  input  logic [NREQ*WIDTH-1:0] req_l_num,
  input  logic [NREQ*WIDTH-1:0] req_l_den,
  input  logic [NREQ*WIDTH-1:0] req_r_num,
  input  logic [NREQ*WIDTH-1:0] req_r_den,
  output logic [NREQ-1:0]       req_ready,
  output logic                  au_enable_sub,
  output logic [WIDTH-1:0]      au_l_num,
  output logic [WIDTH-1:0]      au_l_den,
  output logic [WIDTH-1:0]      au_r_num,
  output logic [WIDTH-1:0]      au_r_den,
  input  logic [WIDTH-1:0]      au_s_num,
  input  logic [WIDTH-1:0]      au_s_den,
  input  logic                  au_rdy,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_num,
  output logic [WIDTH-1:0]      rsp_den,
  output logic                  rsp_timeout
);

  localparam int PW = IDW + 1;
  localparam int CW = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t         state;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] owner;
  logic [CW-1:0]  wait_cnt;

  logic           grant_found;
  logic [IDW-1:0] grant_idx;
  logic [PW-1:0]  cand;

  // Search upward from rr_ptr with wrap; cand is one bit wider so the sum cannot overflow.
  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = {1'b0, rr_ptr} + PW'(i);
      if (cand >= PW'(NREQ)) cand = cand - PW'(NREQ);
      if (!grant_found && req_valid[cand[IDW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[IDW-1:0];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == S_IDLE && !rst && grant_found) req_ready[grant_idx] = 1'b1;
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      rr_ptr        <= '0;
      owner         <= '0;
      wait_cnt      <= '0;
      au_enable_sub <= 1'b0;
      au_l_num      <= '0;
      au_l_den      <= '0;
      au_r_num      <= '0;
      au_r_den      <= '0;
      rsp_valid     <= 1'b0;
      rsp_id        <= '0;
      rsp_num       <= '0;
      rsp_den       <= '0;
      rsp_timeout   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_found) begin
            owner         <= grant_idx;
            au_enable_sub <= req_sub[grant_idx];
            au_l_num      <= req_l_num[grant_idx*WIDTH +: WIDTH];
            au_l_den      <= req_l_den[grant_idx*WIDTH +: WIDTH];
            au_r_num      <= req_r_num[grant_idx*WIDTH +: WIDTH];
            au_r_den      <= req_r_den[grant_idx*WIDTH +: WIDTH];
            rr_ptr        <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
            state         <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          wait_cnt <= '0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          // A result arriving on the last allowed cycle still wins over the timeout.
          if (au_rdy) begin
            rsp_num     <= au_s_num;
            rsp_den     <= au_s_den;
            rsp_timeout <= 1'b0;
            rsp_id      <= owner;
            rsp_valid   <= 1'b1;
            state       <= S_RESP;
          end else if (wait_cnt == CW'(MAX_WAIT - 1)) begin
            rsp_num     <= '0;
            rsp_den     <= '0;
            rsp_timeout <= 1'b1;
            rsp_id      <= owner;
            rsp_valid   <= 1'b1;
            state       <= S_RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rat_add_sub_arbiter.sv
// Bench for rat_add_sub_arbiter: behavioural add_sub unit, round-robin scoreboard,
// a directed vector table and hand-written reset / backpressure sequences.
module tb_rat_add_sub_arbiter;
  localparam int WIDTH = 32, NREQ = 4, IDW = 2, MAX_WAIT = 15;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NREQ-1:0]       req_valid, req_sub, req_ready;
  logic [NREQ*WIDTH-1:0] req_l_num, req_l_den, req_r_num, req_r_den;
  logic                  au_enable_sub, au_rdy;
  logic [WIDTH-1:0]      au_l_num, au_l_den, au_r_num, au_r_den, au_s_num, au_s_den;
  logic                  rsp_valid, rsp_ready, rsp_timeout;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_num, rsp_den;

  rat_add_sub_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_sub(req_sub),
    .req_l_num(req_l_num), .req_l_den(req_l_den), .req_r_num(req_r_num), .req_r_den(req_r_den),
    .req_ready(req_ready),
    .au_enable_sub(au_enable_sub),
    .au_l_num(au_l_num), .au_l_den(au_l_den), .au_r_num(au_r_num), .au_r_den(au_r_den),
    .au_s_num(au_s_num), .au_s_den(au_s_den), .au_rdy(au_rdy),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_num(rsp_num), .rsp_den(rsp_den), .rsp_timeout(rsp_timeout)
  );

  typedef struct { logic sub; logic [WIDTH-1:0] ln, ld, rn, rd; } op_t;
  typedef struct { int id; logic [WIDTH-1:0] num, den; logic to; } exp_t;
  typedef struct {
    int id; op_t op; int extra; bit force_rdy; int hold;
    logic [WIDTH-1:0] num, den; logic to; int lat;
  } vec_t;

  int checks = 0, failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] ref_num(input op_t o);
    return o.sub ? o.ln * o.rd - o.rn * o.ld : o.ln * o.rd + o.rn * o.ld;
  endfunction

  // Behavioural add_sub unit: result from the presented operands, rdy after a chosen delay.
  op_t au_op;
  int  rdy_cnt = 0, cur_extra = 0;
  bit  rdy_force = 1'b0;
  always_comb begin
    au_op.sub = au_enable_sub;
    au_op.ln  = au_l_num;
    au_op.ld  = au_l_den;
    au_op.rn  = au_r_num;
    au_op.rd  = au_r_den;
  end
  assign au_s_num = ref_num(au_op);
  assign au_s_den = au_l_den * au_r_den;
  assign au_rdy   = rdy_force || (rdy_cnt >= 2 && (rdy_cnt - 2) >= cur_extra);
  always @(posedge clk) begin
    if (rst) rdy_cnt <= 0;
    else if (|req_ready) rdy_cnt <= 1;
    else if (rdy_cnt != 0) rdy_cnt <= rdy_cnt + 1;
  end

  op_t             pend [NREQ];
  logic [NREQ-1:0] v, acc_pending;
  int              m_ptr, busy_cycles;
  bit              m_busy, rand_lat;
  exp_t            exp_q [$];
  int              grants [$];

  task automatic drive();
    for (int k = 0; k < NREQ; k++) begin
      req_valid[k] = v[k];
      req_sub[k]   = pend[k].sub;
      req_l_num[k*WIDTH +: WIDTH] = pend[k].ln;
      req_l_den[k*WIDTH +: WIDTH] = pend[k].ld;
      req_r_num[k*WIDTH +: WIDTH] = pend[k].rn;
      req_r_den[k*WIDTH +: WIDTH] = pend[k].rd;
    end
  endtask

  function automatic int pick_extra();
    int r;
    if (!rand_lat) return 0;
    r = $urandom_range(0, 7);
    if (r <= 4) return r;
    if (r == 5) return MAX_WAIT - 1;
    if (r == 6) return MAX_WAIT;
    return 20;
  endfunction

  // One cycle of randomized traffic checked against the round-robin scoreboard.
  task automatic step(input int p_new, input int p_rsp);
    int g, k;
    logic [NREQ-1:0] exp_rr;
    exp_t e;
    @(negedge clk);
    for (int i = 0; i < NREQ; i++)
      if (acc_pending[i]) begin v[i] = 1'b0; acc_pending[i] = 1'b0; end
    for (int i = 0; i < NREQ; i++)
      if (!v[i] && $urandom_range(0, 99) < p_new) begin
        pend[i].sub = 1'($urandom_range(0, 1));
        pend[i].ln = $urandom; pend[i].ld = $urandom;
        pend[i].rn = $urandom; pend[i].rd = $urandom;
        v[i] = 1'b1;
      end
    rsp_ready = ($urandom_range(0, 99) < p_rsp);
    drive();
    #1;
    g = -1;
    if (!m_busy)
      for (int i = 0; i < NREQ; i++) begin
        k = (m_ptr + i) % NREQ;
        if (g < 0 && v[k]) g = k;
      end
    exp_rr = '0;
    if (g >= 0) exp_rr[g] = 1'b1;
    check("req_ready", req_ready, exp_rr);
    for (int i = 0; i < NREQ; i++) if (req_ready[i]) grants.push_back(i);
    if (g >= 0) begin
      m_busy = 1'b1; busy_cycles = 0; m_ptr = (g + 1) % NREQ; acc_pending[g] = 1'b1;
      cur_extra = pick_extra();
      e.id  = g;
      e.to  = (cur_extra >= MAX_WAIT);
      e.num = e.to ? '0 : ref_num(pend[g]);
      e.den = e.to ? '0 : pend[g].ld * pend[g].rd;
      exp_q.push_back(e);
    end else if (m_busy && !rsp_valid) begin
      busy_cycles++;
      if (busy_cycles == 2 * MAX_WAIT + 10) begin
        checks++; failures++;
        $display("FAIL rsp_watchdog: no response after %0d cycles", busy_cycles);
      end
    end
    if (rsp_valid) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_rsp: id %0d with nothing outstanding", rsp_id);
      end else begin
        check("rsp_id", rsp_id, exp_q[0].id);
        check("rsp_num", rsp_num, exp_q[0].num);
        check("rsp_den", rsp_den, exp_q[0].den);
        check("rsp_timeout", rsp_timeout, exp_q[0].to);
        if (rsp_ready) begin void'(exp_q.pop_front()); m_busy = 1'b0; end
      end
    end
  endtask

  // Single directed operation with exact latency, operand hold and optional backpressure.
  task automatic run_vec(input vec_t t);
    int lat;
    bit au_ok, stable_ok;
    logic [NREQ-1:0] exp_rr;
    @(negedge clk);
    rsp_ready = 1'b0; v = '0; pend[t.id] = t.op; v[t.id] = 1'b1;
    cur_extra = t.extra; rdy_force = t.force_rdy;
    drive();
    #1;
    exp_rr = '0; exp_rr[t.id] = 1'b1;
    check("idle_rsp_valid", rsp_valid, 1'b0);
    check("grant", req_ready, exp_rr);
    lat = 0; au_ok = 1'b1;
    while (!rsp_valid && lat < 40) begin
      @(negedge clk);
      if (lat == 0) begin v = '0; drive(); end
      #1;
      lat++;
      if (au_enable_sub !== t.op.sub || au_l_num !== t.op.ln || au_l_den !== t.op.ld ||
          au_r_num !== t.op.rn || au_r_den !== t.op.rd) au_ok = 1'b0;
    end
    check("au_hold", au_ok, 1'b1);
    check("latency", lat, t.lat);
    check("vec_rsp_id", rsp_id, t.id);
    check("vec_rsp_num", rsp_num, t.num);
    check("vec_rsp_den", rsp_den, t.den);
    check("vec_rsp_timeout", rsp_timeout, t.to);
    stable_ok = 1'b1;
    for (int h = 0; h < t.hold; h++) begin
      @(negedge clk);
      if (h == 0) begin
        for (int i = 0; i < NREQ; i++)
          if (i != t.id) begin pend[i] = t.op; v[i] = 1'b1; end
        drive();
      end
      #1;
      if (req_ready !== '0 || rsp_valid !== 1'b1 || rsp_id !== IDW'(t.id) ||
          rsp_num !== t.num || rsp_den !== t.den || rsp_timeout !== t.to) stable_ok = 1'b0;
    end
    if (t.hold > 0) check("backpressure_stable", stable_ok, 1'b1);
    @(negedge clk);
    rsp_ready = 1'b1; v = '0; rdy_force = 1'b0;
    drive();
  endtask

  vec_t vecs [5];
  int   n, lat;

  initial begin
    // {id, {sub, ln, ld, rn, rd}, extra, force_rdy, hold, num, den, timeout, latency}
    vecs[0] = '{1, '{1'b0, 1, 2, 1, 3}, 0,  1'b1, 0,  5,           6,  1'b0, 3};
    vecs[1] = '{0, '{1'b1, 3, 4, 1, 2}, 0,  1'b0, 10, 2,           8,  1'b0, 3};
    vecs[2] = '{2, '{1'b0, 2, 5, 3, 7}, 4,  1'b0, 0,  29,          35, 1'b0, 7};
    vecs[3] = '{3, '{1'b1, 1, 3, 2, 3}, 14, 1'b0, 0,  32'hFFFFFFFD, 9, 1'b0, 17};
    vecs[4] = '{1, '{1'b0, 5, 1, 7, 1}, 15, 1'b0, 0,  0,           0,  1'b1, 17};

    for (int k = 0; k < NREQ; k++) pend[k] = '{1'b0, 0, 0, 0, 0};
    v = '0; acc_pending = '0; rsp_ready = 1'b0; rst = 1'b1;
    m_ptr = 0; m_busy = 1'b0; rand_lat = 1'b0; busy_cycles = 0;
    drive();
    repeat (2) @(negedge clk);
    #1;
    check("rst_req_ready", req_ready, '0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_fields", {rsp_id, rsp_num, rsp_den, rsp_timeout}, '0);
    check("rst_au", |{au_enable_sub, au_l_num, au_l_den, au_r_num, au_r_den}, 1'b0);
    rst = 1'b0;

    // Contention: everybody always valid, grants must rotate 0,1,2,3,0.
    grants.delete();
    n = 0;
    while (grants.size() < 5 && n < 200) begin step(100, 100); n++; end
    check("contention_grants", grants.size() >= 5, 1'b1);
    for (int i = 0; i < 5 && i < grants.size(); i++) check("contention_order", grants[i], i % NREQ);

    rand_lat = 1'b1;
    repeat (1500) step(40, 60);
    n = 0;
    while ((m_busy || v != '0) && n < 3000) begin step(0, 100); n++; end
    check("drain_done", m_busy, 1'b0);
    rand_lat = 1'b0; cur_extra = 0;

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);
    @(negedge clk);
    #1;
    check("release_idle", rsp_valid, 1'b0);
    rsp_ready = 1'b0;

    // Reset during WAIT: requester 2 leaves rr_ptr at 3, reset must bring it back to 0.
    @(negedge clk);
    pend[2] = '{1'b0, 1, 2, 1, 2}; v = '0; v[2] = 1'b1; cur_extra = 20;
    drive();
    #1;
    check("midrst_grant", req_ready, 4'b0100);
    @(negedge clk);
    v = '0; drive();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    pend[1] = '{1'b0, 1, 4, 1, 4}; pend[3] = '{1'b1, 9, 9, 9, 9};
    v = 4'b1010; cur_extra = 0;
    drive();
    #1;
    check("midrst_rsp_valid", rsp_valid, 1'b0);
    check("midrst_rsp_fields", {rsp_id, rsp_num, rsp_den, rsp_timeout}, '0);
    check("midrst_au", |{au_enable_sub, au_l_num, au_l_den, au_r_num, au_r_den}, 1'b0);
    check("midrst_grant_lowest", req_ready, 4'b0010);
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      @(negedge clk);
      if (lat == 0) begin v = '0; drive(); end
      #1;
      lat++;
    end
    check("midrst_latency", lat, 3);
    check("midrst_rsp_id", rsp_id, 1);
    check("midrst_rsp_num", rsp_num, 8);
    check("midrst_rsp_den", rsp_den, 16);
    @(negedge clk);
    rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    check("midrst_done", rsp_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
